// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared types, defaults and helpers for the parametrised LIFO stack
package lifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_PUSHPOP
    } lifo_op_e;

    // Stack pointer must represent 0..DEPTH inclusive.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic lifo_op_e decode_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_PUSHPOP;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module lifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo_stack.sv
// rtl/param_lifo_stack.sv - parametrised LIFO stack with replace-top, flags and optional PARAM_LIFO_STACK_PEEK_EN top-of-stack port
module param_lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 data_in,
    input  logic                             push,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 data_out,
    output logic                             data_valid,
    output logic [$clog2(DEPTH+1)-1:0]       count,
`ifdef PARAM_LIFO_STACK_PEEK_EN
    output logic [WIDTH-1:0]                 top,
`endif
    output logic                             empty,
    output logic                             full,
    output logic                             almost_full,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    sp;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    waddr;
    logic [IW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             we;
    lifo_op_e         op;

    assign op          = decode_op(push, pop);
    assign empty       = (sp == '0);
    assign full        = (sp == PW'(DEPTH));
    assign almost_full = (sp >= PW'(AF_LEVEL));
    assign count       = sp;

    // Top slot is sp-1; steer to 0 when empty so the read never leaves the array.
    assign top_idx = IW'(sp - PW'(1));
    assign raddr   = empty ? '0 : top_idx;
    assign waddr   = (op == OP_PUSH) ? IW'(sp) : top_idx;
    assign we      = ((op == OP_PUSH) && !full) || ((op == OP_PUSHPOP) && !empty);

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef PARAM_LIFO_STACK_PEEK_EN
    assign top = empty ? '0 : rdata;
`endif

    // Pointer, popped-word register and single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp <= sp + PW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        data_out   <= rdata;
                        data_valid <= 1'b1;
                        sp         <= sp - PW'(1);
                    end
                end
                OP_PUSHPOP: begin
                    // Empty stack bypasses the word straight through; otherwise replace top.
                    data_out   <= empty ? data_in : rdata;
                    data_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
